// File: rtl/code_counter.sv
// code_counter: dual-channel event counter with a divide-by-DIV prescaler on channel 1.
// Ports: Clk (rising-edge clock), Reset (sync, active-high), En (count enable),
// Slt (0 = channel 0, 1 = channel 1), Output0/Output1 (registered WIDTH-bit counts).
module code_counter #(
    parameter int WIDTH = 64,
    parameter int DIV   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Slt,
    input  logic             En,
    output logic [WIDTH-1:0] Output0,
    output logic [WIDTH-1:0] Output1
);
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    logic [PW-1:0] pre;
    // pre keeps its partial progress across Slt=0 and En=0 cycles
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Output0 <= '0;
            Output1 <= '0;
            pre     <= '0;
        end else if (En) begin
            if (!Slt)
                Output0 <= Output0 + WIDTH'(1);
            else if (pre == PRE_MAX) begin
                pre     <= '0;
                Output1 <= Output1 + WIDTH'(1);
            end else
                pre <= pre + PW'(1);
        end
    end
endmodule

// File: tb/tb_code_counter.sv
// tb_code_counter: scoreboard bench driving a 64-bit and a 4-bit code_counter in parallel.
module tb_code_counter;
    typedef struct {
        logic [63:0] o0;
        logic [63:0] o1;
    } exp_t;
    logic        Clk, Reset, Slt, En;
    logic [63:0] out0, out1;
    logic [3:0]  n_out0, n_out1;
    exp_t        q[$];
    exp_t        x;
    int          checks = 0;
    int          fails = 0;
    code_counter #(.WIDTH(64), .DIV(4)) dut (
        .Clk(Clk), .Reset(Reset), .Slt(Slt), .En(En), .Output0(out0), .Output1(out1)
    );
    code_counter #(.WIDTH(4), .DIV(4)) dut_n (
        .Clk(Clk), .Reset(Reset), .Slt(Slt), .En(En), .Output0(n_out0), .Output1(n_out1)
    );
    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask
    // Monitor: one entry per edge, sampled 1 time unit after the rising edge
    always @(posedge Clk) begin
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            check("out0", out0, x.o0);
            check("out1", out1, x.o1);
            check("narrow_out0", {60'd0, n_out0}, {60'd0, x.o0[3:0]});
            check("narrow_out1", {60'd0, n_out1}, {60'd0, x.o1[3:0]});
        end
    end
    task automatic step(input logic r, input logic e, input logic s,
                        input logic [63:0] x0, input logic [63:0] x1);
        @(negedge Clk);
        Reset = r;
        En    = e;
        Slt   = s;
        q.push_back('{x0, x1});
    endtask
    initial begin
        Reset = 1;
        En    = 1;
        Slt   = 0;
        // reset with En high and Slt toggling
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        // channel 0 counts 1..10
        for (int i = 1; i <= 10; i++) step(0, 1, 0, 64'(i), 0);
        // channel 1: increments on 4th and 8th edge
        step(0, 1, 1, 10, 0);
        step(0, 1, 1, 10, 0);
        step(0, 1, 1, 10, 0);
        step(0, 1, 1, 10, 1);
        step(0, 1, 1, 10, 1);
        step(0, 1, 1, 10, 1);
        step(0, 1, 1, 10, 1);
        step(0, 1, 1, 10, 2);
        // interruptions keep the prescaler at 3
        step(0, 1, 1, 10, 2);
        step(0, 1, 1, 10, 2);
        step(0, 1, 1, 10, 2);
        step(0, 1, 0, 11, 2);
        step(0, 1, 0, 12, 2);
        step(0, 0, 1, 12, 2);
        step(0, 0, 1, 12, 2);
        step(0, 1, 1, 12, 3);
        // reset priority over En, and it clears the prescaler
        step(0, 1, 0, 13, 3);
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 1);
        // wrap: narrow instance reads 15, 0, 1 at edges 15, 16, 17
        step(1, 1, 0, 0, 0);
        for (int i = 1; i <= 17; i++) step(0, 1, 0, 64'(i), 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge Clk);
        @(negedge Clk);
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
